wm_phase_sequencer: RTL and testbench

- Timed phase sequencer for the wash drum datapath: fill, wash, drain, rinse, spin.
- Sits below the top-level washing machine controller, which issues start, pause and abort.
- Owns the pump valves, motor enable and speed, door lock, and the countdown shown on the display.
- Derives a seconds tick from clk and flags sensor timeouts and lid faults with a fault code.

---
 rtl/wm_phase_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_wm_phase_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wm_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : wm_phase_sequencer
//  Purpose  : Timed phase sequencer for the wash drum datapath
//             (fill, wash, drain, rinse, spin). Derives a tick from clk,
//             counts down each phase, drives pumps/motor/door lock and
//             reports lid and water-sensor timeout faults.
//  Option   : WM_PREWASH_EN - when defined, FILL exits to a 3-tick PREWASH
//             before WASH; when undefined, encoding 2 is never entered.
//  Ports    : clk, reset (async, active-high)
//             start/abort (pulses), pause (level), cycle_select[1:0],
//             spin_speed_select[1:0], water_full, water_empty, lid_closed
//             -> pump_fill, pump_drain, motor_on, motor_speed[1:0],
//                door_locked, phase[3:0], time_left[TIMER_W-1:0], busy,
//                done, fault, fault_code[1:0]
//  Revision : 1.0 - initial release
// ============================================================================
module wm_phase_sequencer #(
  parameter int TICK_DIV     = 100,
  parameter int TIMER_W      = 8,
  parameter int FILL_TIMEOUT = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               abort,
  input  logic [1:0]         cycle_select,
  input  logic [1:0]         spin_speed_select,
  input  logic               water_full,
  input  logic               water_empty,
  input  logic               lid_closed,
  output logic               pump_fill,
  output logic               pump_drain,
  output logic               motor_on,
  output logic [1:0]         motor_speed,
  output logic               door_locked,
  output logic [3:0]         phase,
  output logic [TIMER_W-1:0] time_left,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [1:0]         fault_code
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FILL    = 4'd1,
    S_PREWASH = 4'd2,
    S_WASH    = 4'd3,
    S_DRAIN   = 4'd4,
    S_RINSE   = 4'd5,
    S_SPIN    = 4'd6,
    S_DONE    = 4'd7,
    S_FAULT   = 4'd8
  } state_t;

  localparam logic [15:0]        c_presc_last = 16'(TICK_DIV - 1);
  localparam logic [TIMER_W-1:0] c_fill_to    = TIMER_W'(FILL_TIMEOUT);
  localparam logic [TIMER_W-1:0] c_one        = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] c_rinse_len  = TIMER_W'(4);

  function automatic logic [TIMER_W-1:0] f_wash_len(input logic [1:0] sel);
    case (sel)
      2'b00:   return TIMER_W'(5);
      2'b01:   return TIMER_W'(10);
      2'b10:   return TIMER_W'(15);
      default: return TIMER_W'(8);
    endcase
  endfunction

  function automatic logic [TIMER_W-1:0] f_spin_len(input logic [1:0] sel);
    case (sel)
      2'b00:   return TIMER_W'(3);
      2'b01:   return TIMER_W'(5);
      default: return TIMER_W'(7);
    endcase
  endfunction

  state_t             r_state, w_state_nxt;
  logic [15:0]        r_presc, w_presc_nxt;
  logic [TIMER_W-1:0] r_time,  w_time_nxt;
  logic [1:0]         r_cyc,   w_cyc_nxt;
  logic [1:0]         r_spd,   w_spd_nxt;
  logic               r_abort, w_abort_nxt;
  logic [1:0]         r_fcode, w_fcode_nxt;

  logic w_active;
  logic w_tick;
  logic w_last;

  assign w_active = (r_state == S_FILL)  || (r_state == S_PREWASH) ||
                    (r_state == S_WASH)  || (r_state == S_DRAIN)   ||
                    (r_state == S_RINSE) || (r_state == S_SPIN);
  assign w_tick   = (r_presc == c_presc_last);
  assign w_last   = (r_time == c_one);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      r_time  <= '0;
      r_cyc   <= '0;
      r_spd   <= '0;
      r_abort <= 1'b0;
      r_fcode <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_time  <= w_time_nxt;
      r_cyc   <= w_cyc_nxt;
      r_spd   <= w_spd_nxt;
      r_abort <= w_abort_nxt;
      r_fcode <= w_fcode_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_time_nxt  = r_time;
    w_cyc_nxt   = r_cyc;
    w_spd_nxt   = r_spd;
    w_abort_nxt = r_abort;
    w_fcode_nxt = r_fcode;

    case (r_state)
      S_IDLE: begin
        w_presc_nxt = '0;
        w_time_nxt  = '0;
        w_abort_nxt = 1'b0;
        if (start) begin
          if (lid_closed) begin
            w_cyc_nxt   = cycle_select;
            w_spd_nxt   = spin_speed_select;
            w_state_nxt = S_FILL;
            w_time_nxt  = c_fill_to;
          end else begin
            w_state_nxt = S_FAULT;
            w_fcode_nxt = 2'b01;
          end
        end
      end

      S_DONE: begin
        w_presc_nxt = '0;
        w_time_nxt  = '0;
        w_state_nxt = S_IDLE;
      end

      S_FAULT: begin
        w_presc_nxt = '0;
        w_time_nxt  = '0;
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_fcode_nxt = 2'b00;
        end
      end

      S_FILL, S_PREWASH, S_WASH, S_DRAIN, S_RINSE, S_SPIN: begin
        if (!lid_closed) begin
          w_state_nxt = S_FAULT;
          w_fcode_nxt = 2'b01;
          w_presc_nxt = '0;
          w_time_nxt  = '0;
        end else if (abort) begin
          // In DRAIN the abort only marks the program as cancelled; the
          // phase holds for that cycle and exits to IDLE once empty.
          w_abort_nxt = 1'b1;
          if (r_state != S_DRAIN) begin
            w_state_nxt = S_DRAIN;
            w_time_nxt  = c_fill_to;
            w_presc_nxt = '0;
          end
        end else if (!pause) begin
          w_presc_nxt = w_tick ? '0 : r_presc + 16'd1;
          if (w_tick) w_time_nxt = r_time - c_one;
          case (r_state)
            S_FILL: begin
              if (water_full) begin
`ifdef WM_PREWASH_EN
                w_state_nxt = S_PREWASH;
                w_time_nxt  = TIMER_W'(3);
`else
                w_state_nxt = S_WASH;
                w_time_nxt  = f_wash_len(r_cyc);
`endif
                w_presc_nxt = '0;
              end else if (w_tick && w_last) begin
                w_state_nxt = S_FAULT;
                w_fcode_nxt = 2'b10;
                w_time_nxt  = '0;
                w_presc_nxt = '0;
              end
            end
`ifdef WM_PREWASH_EN
            S_PREWASH: begin
              if (w_tick && w_last) begin
                w_state_nxt = S_WASH;
                w_time_nxt  = f_wash_len(r_cyc);
                w_presc_nxt = '0;
              end
            end
`endif
            S_WASH: begin
              if (w_tick && w_last) begin
                w_state_nxt = S_DRAIN;
                w_time_nxt  = c_fill_to;
                w_presc_nxt = '0;
              end
            end
            S_DRAIN: begin
              if (water_empty) begin
                if (r_abort) begin
                  w_state_nxt = S_IDLE;
                  w_abort_nxt = 1'b0;
                  w_time_nxt  = '0;
                end else begin
                  w_state_nxt = S_RINSE;
                  w_time_nxt  = c_rinse_len;
                end
                w_presc_nxt = '0;
              end else if (w_tick && w_last) begin
                w_state_nxt = S_FAULT;
                w_fcode_nxt = 2'b11;
                w_time_nxt  = '0;
                w_presc_nxt = '0;
              end
            end
            S_RINSE: begin
              if (w_tick && w_last) begin
                w_state_nxt = S_SPIN;
                w_time_nxt  = f_spin_len(r_spd);
                w_presc_nxt = '0;
              end
            end
            S_SPIN: begin
              if (w_tick && w_last) begin
                w_state_nxt = S_DONE;
                w_time_nxt  = '0;
                w_presc_nxt = '0;
              end
            end
            default: ;
          endcase
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_presc_nxt = '0;
        w_time_nxt  = '0;
      end
    endcase
  end

  // Actuators decode from the registered state; pause gates them off
  // combinationally while the door lock is held.
  always_comb begin
    pump_fill   = 1'b0;
    pump_drain  = 1'b0;
    motor_on    = 1'b0;
    motor_speed = 2'b00;
    door_locked = 1'b0;
    phase       = r_state;
    time_left   = r_time;
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);
    fault       = (r_state == S_FAULT);
    fault_code  = r_fcode;

    if (w_active) begin
      door_locked = 1'b1;
      if (!pause) begin
        case (r_state)
          S_FILL:    pump_fill = 1'b1;
          S_PREWASH: motor_on  = 1'b1;
          S_WASH: begin
            motor_on    = 1'b1;
            motor_speed = (r_cyc == 2'b11) ? 2'b00 : 2'b01;
          end
          S_DRAIN:   pump_drain = 1'b1;
          S_RINSE: begin
            pump_fill = 1'b1;
            motor_on  = 1'b1;
          end
          S_SPIN: begin
            pump_drain  = 1'b1;
            motor_on    = 1'b1;
            motor_speed = (r_spd == 2'b11) ? 2'b10 : r_spd;
          end
          default: ;
        endcase
      end
    end else if (r_state == S_FAULT) begin
      // Keep the door shut while water remains in the drum.
      door_locked = !water_empty;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wm_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wm_phase_sequencer
//  Purpose  : Self-checking bench for wm_phase_sequencer (default build,
//             WM_PREWASH_EN undefined). Reference expectations come from
//             program duration tables and per-phase cycle budgets.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wm_phase_sequencer;

  localparam int TD = 4;
  localparam int FT = 5;

  logic       clk = 1'b0;
  logic       reset, start, pause, abort;
  logic [1:0] cycle_select, spin_speed_select;
  logic       water_full, water_empty, lid_closed;
  logic       pump_fill, pump_drain, motor_on, door_locked;
  logic [1:0] motor_speed;
  logic [3:0] phase;
  logic [7:0] time_left;
  logic       busy, done, fault;
  logic [1:0] fault_code;

  int checks = 0;
  int errors = 0;

  // Program tables in ticks, indexed by the select codes.
  int wash_ticks[4] = '{5, 10, 15, 8};
  int spin_ticks[4] = '{3, 5, 7, 7};

  always #5 clk = ~clk;

  wm_phase_sequencer #(
    .TICK_DIV    (TD),
    .TIMER_W     (8),
    .FILL_TIMEOUT(FT)
  ) u_dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .pause            (pause),
    .abort            (abort),
    .cycle_select     (cycle_select),
    .spin_speed_select(spin_speed_select),
    .water_full       (water_full),
    .water_empty      (water_empty),
    .lid_closed       (lid_closed),
    .pump_fill        (pump_fill),
    .pump_drain       (pump_drain),
    .motor_on         (motor_on),
    .motor_speed      (motor_speed),
    .door_locked      (door_locked),
    .phase            (phase),
    .time_left        (time_left),
    .busy             (busy),
    .done             (done),
    .fault            (fault),
    .fault_code       (fault_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input logic [3:0] ph, input string tag);
    int n = 0;
    while (phase !== ph && n < 1000) begin
      step();
      n++;
    end
    chk(tag, 32'(phase), 32'(ph));
  endtask

  // mode 0: plain run, mode 1: 10-cycle pause in WASH at time_left 3,
  // mode 2: abort on the third RINSE cycle.
  task automatic run_prog(input int cs, input int ss, input int mode);
    int          cnt[16];
    int          nseq = 0;
    int          dones = 0;
    int          n = 0;
    logic [31:0] seqv = '0;
    logic [3:0]  last = 4'hF;
    bit          pz_done = 1'b0;
    bit          ab_done = 1'b0;
    bit          wash_seen = 1'b0;
    bit          spin_seen = 1'b0;
    foreach (cnt[i]) cnt[i] = 0;
    cycle_select      = 2'(cs);
    spin_speed_select = 2'(ss);
    start = 1'b1;
    step();
    start = 1'b0;
    while (phase != 4'd0 && n < 1000) begin
      abort = 1'b0;
      if (phase != last) begin
        if (nseq < 8) seqv = seqv | (32'(phase) << (4 * nseq));
        nseq++;
        last = phase;
      end
      cnt[phase]++;
      if (done) dones++;
      if (phase == 4'd3 && !wash_seen) begin
        wash_seen = 1'b1;
        chk("wash_len", 32'(time_left), wash_ticks[cs]);
        chk("wash_speed", 32'(motor_speed), (cs == 3) ? 0 : 1);
        chk("wash_motor", 32'(motor_on), 1);
      end
      if (phase == 4'd6 && !spin_seen) begin
        spin_seen = 1'b1;
        chk("spin_speed", 32'(motor_speed), (ss == 3) ? 2 : ss);
        chk("spin_act", 32'({motor_on, pump_drain, door_locked}), 7);
      end
      if (phase == 4'd7) begin
        chk("done_door", 32'(door_locked), 0);
        chk("done_pulse", 32'(done), 1);
      end
      if (mode == 1 && phase == 4'd3 && time_left == 8'd3 && !pz_done) begin
        pz_done = 1'b1;
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
          step();
          n++;
          cnt[phase]++;
          chk("pause_act", 32'({pump_fill, pump_drain, motor_on}), 0);
          chk("pause_tl", 32'(time_left), 3);
          chk("pause_lock", 32'(door_locked), 1);
        end
        pause = 1'b0;
      end
      if (mode == 2 && phase == 4'd5 && cnt[5] == 3 && !ab_done) begin
        ab_done = 1'b1;
        abort = 1'b1;
      end else if (mode == 2 && ab_done && phase == 4'd4) begin
        chk("abort_drain", 32'(pump_drain), 1);
        chk("abort_tl", 32'(time_left), FT);
      end
      step();
      n++;
    end
    abort = 1'b0;
    chk("prog_end", 32'(phase), 0);
    chk("done_count", dones, (mode == 2) ? 0 : 1);
    if (mode == 2) begin
      chk("abort_seq", seqv, 32'h0004_5431);
    end else begin
      chk("seq", seqv, 32'h0076_5431);
      chk("wash_cycles", cnt[3], TD * wash_ticks[cs] + ((mode == 1) ? 10 : 0));
      chk("rinse_cycles", cnt[5], TD * 4);
      chk("spin_cycles", cnt[6], TD * spin_ticks[ss]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
    cycle_select = 2'b00; spin_speed_select = 2'b00;
    water_full = 1'b1; water_empty = 1'b1; lid_closed = 1'b1;
    step();
    step();
    chk("reset_outs", 32'({pump_fill, pump_drain, motor_on, door_locked, motor_speed,
                           phase, time_left, busy, done, fault, fault_code}), 0);
    reset = 1'b0;
    step();

    // Quick program, medium spin, instant sensors.
    run_prog(0, 1, 0);
    // Randomized programs.
    for (int r = 0; r < 4; r++) begin
      run_prog(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
    end
    // Pause mid-WASH.
    run_prog(0, 1, 1);
    // Abort during RINSE.
    run_prog(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2);

    // Fill timeout.
    water_full = 1'b0;
    cycle_select = 2'b01;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (phase == 4'd1 && n < 200) begin
      n++;
      step();
    end
    chk("fill_cycles", n, TD * FT);
    chk("fill_to_phase", 32'(phase), 8);
    chk("fill_to_code", 32'(fault_code), 2);
    chk("fill_to_flags", 32'({fault, busy, pump_fill, door_locked}), 4'b1100);
    water_empty = 1'b0;
    #1;
    chk("fault_door_wet", 32'(door_locked), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("fault_ign_start", 32'(phase), 8);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("fault_clear", 32'({phase, fault, fault_code}), 0);
    water_full = 1'b1;
    water_empty = 1'b1;
    step();

    // Lid drop in SPIN with pause and abort in the same cycle.
    cycle_select = 2'b00;
    spin_speed_select = 2'b10;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_phase(4'd6, "reach_spin");
    water_empty = 1'b0;
    pause = 1'b1;
    lid_closed = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("lid_phase", 32'(phase), 8);
    chk("lid_code", 32'(fault_code), 1);
    chk("lid_act", 32'({pump_fill, pump_drain, motor_on}), 0);
    chk("lid_door_wet", 32'(door_locked), 1);
    water_empty = 1'b1;
    #1;
    chk("lid_door_dry", 32'(door_locked), 0);
    lid_closed = 1'b1;
    pause = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("lid_clear", 32'({phase, fault_code}), 0);

    // Asynchronous reset mid-WASH, then start with the lid open.
    cycle_select = 2'b01;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_phase(4'd3, "reach_wash");
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", 32'({pump_fill, pump_drain, motor_on, door_locked, motor_speed,
                            phase, time_left, busy, done, fault, fault_code}), 0);
    step();
    reset = 1'b0;
    lid_closed = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("lid_open_start", 32'({phase, fault_code}), {4'd8, 2'b01});
    lid_closed = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("final_idle", 32'(phase), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
